// File: rtl/uart_boot_bridge.sv
// UART boot bridge: hunts a byte stream for a framed image
// (sync, 16-bit little-endian word count, payload, 8-bit checksum), writes the
// payload into an internal DEPTH x 32 byte-lane SRAM, then releases the core
// reset and serves the picorv32 native memory bus (SRAM plus an LED register).
//
// Ports:
//   clk, nRST                 clock and synchronous active-low reset
//   rx_valid, rx_data         byte stream from uart_rx
//   rx_ready                  byte consumed when rx_valid & rx_ready
//   core_resetn               picorv32 reset, high once a good image is loaded
//   mem_valid/addr/wdata/wstrb  picorv32 request (wstrb == 0 means read)
//   mem_ready, mem_rdata      one-cycle response strobe and read data
//   leds                      MMIO LED register
//   boot_err                  sticky: last frame was rejected
//   state_dbg                 current FSM state encoding
module uart_boot_bridge #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [7:0]  SYNC_BYTE = 8'h53,
  parameter logic [31:0] LED_ADDR  = 32'h1000_0000,
  parameter int unsigned TIMEOUT   = 1_000_000
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        core_resetn,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic [7:0]  leds,
  output logic        boot_err,
  output logic [2:0]  state_dbg
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    StHunt = 3'd0,
    StLen0 = 3'd1,
    StLen1 = 3'd2,
    StData = 3'd3,
    StCsum = 3'd4,
    StRun  = 3'd5,
    StErr  = 3'd6
  } state_e;

  state_e        state;
  logic [7:0]    csum;
  logic [7:0]    len_lo;
  logic [AW-1:0] ptr;
  logic [AW-1:0] last_word;
  logic [1:0]    lane;
  logic [TW-1:0] idle;

  logic [31:0]   sram [DEPTH];

  logic          rx_fire;
  logic          timed_out;
  logic [15:0]   len_full;
  logic          led_hit;
  logic          sram_hit;
  logic          bus_take;
  logic          boot_we;
  logic          core_we;
  logic [3:0]    we_be;
  logic [AW-1:0] we_addr;
  logic [31:0]   we_data;

  assign state_dbg = state;
  assign rx_fire   = rx_valid & rx_ready;
  assign timed_out = (idle == TW'(TIMEOUT - 1));
  assign len_full  = {rx_data, len_lo};
  assign led_hit   = (mem_addr == LED_ADDR);
  assign sram_hit  = (mem_addr[31:AW+2] == '0);
  // A request seen while ready is high is the tail of the previous transfer.
  assign bus_take  = (state == StRun) & mem_valid & ~mem_ready;

  // SRAM write port shared by the loader (one lane per byte) and the core.
  always_comb begin
    boot_we = nRST & (state == StData) & rx_fire;
    core_we = nRST & bus_take & ~led_hit & sram_hit & (mem_wstrb != 4'b0000);
    we_be   = 4'b0000;
    we_addr = mem_addr[AW+1:2];
    we_data = mem_wdata;
    if (boot_we) begin
      we_be   = 4'b0001 << lane;
      we_addr = ptr;
      we_data = {4{rx_data}};
    end else if (core_we) begin
      we_be   = mem_wstrb;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we_be[i]) sram[we_addr][8*i +: 8] <= we_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!nRST) begin
      state       <= StHunt;
      rx_ready    <= 1'b0;
      core_resetn <= 1'b0;
      mem_ready   <= 1'b0;
      mem_rdata   <= '0;
      leds        <= '0;
      boot_err    <= 1'b0;
      csum        <= '0;
      len_lo      <= '0;
      ptr         <= '0;
      last_word   <= '0;
      lane        <= '0;
      idle        <= '0;
    end else begin
      mem_ready <= 1'b0;

      // Idle clocks only matter while a frame is in progress.
      if (rx_fire || state == StHunt || state == StRun || state == StErr) begin
        idle <= '0;
      end else begin
        idle <= idle + TW'(1);
      end

      case (state)
        StHunt: begin
          rx_ready <= 1'b1;
          if (rx_fire && rx_data == SYNC_BYTE) begin
            state <= StLen0;
            csum  <= '0;
          end
        end

        StLen0: begin
          if (rx_fire) begin
            len_lo <= rx_data;
            csum   <= csum + rx_data;
            state  <= StLen1;
          end else if (timed_out) begin
            state    <= StErr;
            boot_err <= 1'b1;
            rx_ready <= 1'b0;
          end
        end

        StLen1: begin
          if (rx_fire) begin
            csum <= csum + rx_data;
            if (32'(len_full) > DEPTH) begin
              state    <= StErr;
              boot_err <= 1'b1;
              rx_ready <= 1'b0;
            end else if (len_full == 16'd0) begin
              state <= StCsum;
            end else begin
              state     <= StData;
              ptr       <= '0;
              lane      <= '0;
              last_word <= AW'(len_full - 16'd1);
            end
          end else if (timed_out) begin
            state    <= StErr;
            boot_err <= 1'b1;
            rx_ready <= 1'b0;
          end
        end

        StData: begin
          if (rx_fire) begin
            csum <= csum + rx_data;
            lane <= lane + 2'd1;
            if (lane == 2'd3) begin
              ptr <= ptr + AW'(1);
              if (ptr == last_word) state <= StCsum;
            end
          end else if (timed_out) begin
            state    <= StErr;
            boot_err <= 1'b1;
            rx_ready <= 1'b0;
          end
        end

        StCsum: begin
          if (rx_fire) begin
            rx_ready <= 1'b0;
            if (rx_data == csum) begin
              state       <= StRun;
              boot_err    <= 1'b0;
              core_resetn <= 1'b1;
            end else begin
              state    <= StErr;
              boot_err <= 1'b1;
            end
          end else if (timed_out) begin
            state    <= StErr;
            boot_err <= 1'b1;
            rx_ready <= 1'b0;
          end
        end

        StRun: begin
          core_resetn <= 1'b1;
          if (bus_take) begin
            mem_ready <= 1'b1;
            if (mem_wstrb != 4'b0000) begin
              mem_rdata <= '0;
              if (led_hit && mem_wstrb[0]) leds <= mem_wdata[7:0];
            end else if (led_hit) begin
              mem_rdata <= {24'b0, leds};
            end else if (sram_hit) begin
              mem_rdata <= sram[mem_addr[AW+1:2]];
            end else begin
              mem_rdata <= '0;
            end
          end
        end

        StErr: begin
          state    <= StHunt;
          rx_ready <= 1'b1;
        end

        default: begin
          state    <= StHunt;
          rx_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_boot_bridge.sv
// Directed bench for uart_boot_bridge: framing, checksum, length and timeout
// errors, byte-strobe SRAM writes, LED MMIO, bus handshake and reset in RUN.
module tb_uart_boot_bridge;

  localparam int unsigned DEPTH   = 1024;
  localparam int unsigned TIMEOUT = 40;

  localparam logic [2:0] S_HUNT = 3'd0;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_RUN  = 3'd5;
  localparam logic [2:0] S_ERR  = 3'd6;

  logic        clk = 1'b0;
  logic        nRST;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        core_resetn;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [7:0]  leds;
  logic        boot_err;
  logic [2:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  uart_boot_bridge #(
    .DEPTH    (DEPTH),
    .SYNC_BYTE(8'h53),
    .LED_ADDR (32'h1000_0000),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk        (clk),
    .nRST       (nRST),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .core_resetn(core_resetn),
    .mem_valid  (mem_valid),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .leds       (leds),
    .boot_err   (boot_err),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Present one byte and hold it until the bridge accepts it (bounded).
  task automatic send(input logic [7:0] b);
    logic done;
    done     = 1'b0;
    rx_valid = 1'b1;
    rx_data  = b;
    for (int i = 0; i < 20 && !done; i++) begin
      if (rx_ready) done = 1'b1;
      cycle();
    end
    rx_valid = 1'b0;
    chk("rx_accept", {31'b0, done}, 32'd1);
  endtask

  // Single bus transfer followed by one idle cycle; read data checked on reads.
  task automatic bus(input string tag, input logic [31:0] addr, input logic [3:0] strb,
                     input logic [31:0] wdata, input logic [31:0] exp_rdata);
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wstrb = strb;
    mem_wdata = wdata;
    cycle();
    chk({tag, "_ready"}, {31'b0, mem_ready}, 32'd1);
    chk({tag, "_rdata"}, mem_rdata, exp_rdata);
    mem_valid = 1'b0;
    cycle();
    chk({tag, "_ready_low"}, {31'b0, mem_ready}, 32'd0);
    chk({tag, "_rdata_hold"}, mem_rdata, exp_rdata);
  endtask

  initial begin
    nRST      = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    mem_valid = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_wstrb = 4'h0;
    cycle();
    cycle();
    chk("rst_state", {29'b0, state_dbg}, {29'b0, S_HUNT});
    chk("rst_core_resetn", {31'b0, core_resetn}, 32'd0);
    chk("rst_mem_ready", {31'b0, mem_ready}, 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'd0);
    chk("rst_leds", {24'b0, leds}, 32'd0);
    chk("rst_boot_err", {31'b0, boot_err}, 32'd0);
    chk("rst_rx_ready", {31'b0, rx_ready}, 32'd0);
    nRST = 1'b1;

    // Noise, then a length of 0x0401 = 1025 words, one more than DEPTH.
    send(8'h00);
    send(8'hFF);
    send(8'h53);
    send(8'h01);
    send(8'h04);
    chk("len_err_state", {29'b0, state_dbg}, {29'b0, S_ERR});
    chk("len_err_flag", {31'b0, boot_err}, 32'd1);
    chk("len_err_rx_ready", {31'b0, rx_ready}, 32'd0);
    cycle();
    chk("len_err_hunt", {29'b0, state_dbg}, {29'b0, S_HUNT});

    // One-word frame with a wrong checksum (correct sum is 0x39).
    send(8'h53); send(8'h01); send(8'h00);
    send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
    send(8'h00);
    chk("bad_csum_state", {29'b0, state_dbg}, {29'b0, S_ERR});
    cycle();
    chk("bad_csum_hunt", {29'b0, state_dbg}, {29'b0, S_HUNT});
    chk("bad_csum_flag", {31'b0, boot_err}, 32'd1);
    chk("bad_csum_core", {31'b0, core_resetn}, 32'd0);

    // Good frame: 01+00+EF+BE+AD+DE = 0x339 -> 0x39.
    send(8'h53); send(8'h01); send(8'h00);
    send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
    send(8'h39);
    chk("good_state", {29'b0, state_dbg}, {29'b0, S_RUN});
    chk("good_core", {31'b0, core_resetn}, 32'd1);
    chk("good_flag", {31'b0, boot_err}, 32'd0);
    chk("good_rx_ready", {31'b0, rx_ready}, 32'd0);

    bus("rd_w0", 32'h0000_0000, 4'b0000, 32'h0, 32'hDEAD_BEEF);

    // A request held high is served every other cycle.
    mem_valid = 1'b1;
    mem_addr  = 32'h0000_0000;
    mem_wstrb = 4'b0000;
    cycle(); chk("hold_ready0", {31'b0, mem_ready}, 32'd1);
    cycle(); chk("hold_ready1", {31'b0, mem_ready}, 32'd0);
    cycle(); chk("hold_ready2", {31'b0, mem_ready}, 32'd1);
    cycle(); chk("hold_ready3", {31'b0, mem_ready}, 32'd0);
    mem_valid = 1'b0;
    cycle();

    bus("wr_lane2", 32'h0000_0000, 4'b0100, 32'h00AA_0000, 32'h0);
    bus("rd_lane2", 32'h0000_0000, 4'b0000, 32'h0, 32'hDEAA_BEEF);
    bus("wr_w5", 32'h0000_0014, 4'b1111, 32'h1234_5678, 32'h0);
    bus("rd_w5", 32'h0000_0014, 4'b0000, 32'h0, 32'h1234_5678);
    // Just past the SRAM window: must not alias word 0.
    bus("rd_oob", 32'h0000_1000, 4'b0000, 32'h0, 32'h0);

    bus("wr_led", 32'h1000_0000, 4'b0001, 32'h0000_005A, 32'h0);
    chk("leds_5a", {24'b0, leds}, 32'h5A);
    bus("rd_led", 32'h1000_0000, 4'b0000, 32'h0, 32'h0000_005A);
    bus("rd_unmapped", 32'h2000_0000, 4'b0000, 32'h0, 32'h0);

    // rx traffic is ignored in RUN.
    rx_valid = 1'b1;
    rx_data  = 8'h53;
    cycle(); cycle(); cycle();
    chk("run_rx_ready", {31'b0, rx_ready}, 32'd0);
    chk("run_rx_ignored", {29'b0, state_dbg}, {29'b0, S_RUN});
    rx_valid = 1'b0;

    // Reset in RUN.
    nRST = 1'b0;
    cycle();
    chk("rst_run_core", {31'b0, core_resetn}, 32'd0);
    chk("rst_run_leds", {24'b0, leds}, 32'd0);
    chk("rst_run_state", {29'b0, state_dbg}, {29'b0, S_HUNT});
    nRST = 1'b1;

    // Stall inside DATA: ERR on exactly the TIMEOUT-th idle clock.
    send(8'h53); send(8'h01); send(8'h00); send(8'hEF);
    repeat (TIMEOUT - 1) cycle();
    chk("tmo_not_yet", {29'b0, state_dbg}, {29'b0, S_DATA});
    cycle();
    chk("tmo_state", {29'b0, state_dbg}, {29'b0, S_ERR});
    chk("tmo_flag", {31'b0, boot_err}, 32'd1);
    cycle();

    // Zero-length frame goes straight to the checksum; SRAM survived reset.
    send(8'h53); send(8'h00); send(8'h00); send(8'h00);
    chk("len0_state", {29'b0, state_dbg}, {29'b0, S_RUN});
    chk("len0_flag", {31'b0, boot_err}, 32'd0);
    chk("len0_leds", {24'b0, leds}, 32'd0);
    bus("rd_after_rst", 32'h0000_0000, 4'b0000, 32'h0, 32'hDEAA_BEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
